// File: rtl/alu_pkg.sv
// Shared VeriRISC type definitions: instruction opcodes used by the ALU,
// controller and instruction register.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

// File: rtl/alu.sv
// VeriRISC ALU: opcode-selected result registered on the falling clock edge,
// plus a combinational accumulator-zero flag. Optional carry output: ALU_CARRY_EN.
module alu
  import typedefs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out,
`ifdef ALU_CARRY_EN
  output logic             carry,
`endif
  output logic             zero
);

  logic [WIDTH-1:0] out_d, out_q;

`ifdef ALU_CARRY_EN
  logic [WIDTH:0] sum;
  logic           carry_d, carry_q;

  assign sum = {1'b0, accum} + {1'b0, data};
`endif

  // Unknown opcodes deliberately propagate X into the result.
  always_comb begin
    out_d = 'x;
`ifdef ALU_CARRY_EN
    carry_d = 1'b0;
`endif
    unique case (opcode)
      HLT, SKZ, STO, JMP: out_d = accum;
      ADD: begin
`ifdef ALU_CARRY_EN
        out_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
`else
        out_d   = accum + data;
`endif
      end
      AND:     out_d = data & accum;
      XOR:     out_d = data ^ accum;
      LDA:     out_d = data;
      default: out_d = 'x;
    endcase
  end

  // Falling edge gives the accumulator a stable value by the next rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      out_q <= '0;
`ifdef ALU_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      out_q <= out_d;
`ifdef ALU_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign out  = out_q;
`ifdef ALU_CARRY_EN
  assign carry = carry_q;
`endif
  assign zero = (accum == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized stimulus
// against an arithmetic reference model.
module tb_alu;
  import typedefs::*;

  logic       clk;
  logic       rst;
  opcode_t    opcode;
  logic [7:0] accum;
  logic [7:0] data;
  logic [7:0] out;
  logic       zero;
`ifdef ALU_CARRY_EN
  logic       carry;
`endif

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .accum  (accum),
    .data   (data),
    .out    (out),
`ifdef ALU_CARRY_EN
    .carry  (carry),
`endif
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_out(int unsigned op, int unsigned a, int unsigned d);
    case (op)
      2: return (a + d) % 256;
      3: return a & d;
      4: return a ^ d;
      5: return d;
      default: return a;
    endcase
  endfunction

  function automatic int unsigned model_carry(int unsigned op, int unsigned a, int unsigned d);
    return (op == 2 && (a + d) > 255) ? 1 : 0;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic run(input string tag, input int unsigned op, input int unsigned a,
                     input int unsigned d, input bit r);
    int unsigned exp_out, exp_c;
    opcode = opcode_t'(op[2:0]);
    accum  = a[7:0];
    data   = d[7:0];
    rst    = r;
    #1;
    check({tag, ".zero"}, {31'b0, zero}, (a == 0) ? 32'd1 : 32'd0);
    exp_out = r ? 0 : model_out(op, a, d);
    exp_c   = r ? 0 : model_carry(op, a, d);
    @(posedge clk);
    #1;
    check({tag, ".out"}, {24'b0, out}, exp_out);
`ifdef ALU_CARRY_EN
    check({tag, ".carry"}, {31'b0, carry}, exp_c);
`else
    if (exp_c > 1) check({tag, ".carry"}, exp_c, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; opcode = HLT; accum = 8'h5A; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", {24'b0, out}, 32'd0);
    check("reset.zero", {31'b0, zero}, 32'd0);

    run("addwrap", 2, 8'hFF, 8'h01, 1'b0);

    for (int op = 0; op < 8; op++) run($sformatf("pass%0d", op), op, 8'hA5, 8'h3C, 1'b0);

    run("zlda", 5, 8'h00, 8'h7F, 1'b0);
    accum = 8'h01;
    #1;
    check("zfall", {31'b0, zero}, 32'd0);
    check("zhold.out", {24'b0, out}, 32'h7F);

    run("rstadd", 2, 8'h10, 8'h20, 1'b1);
    run("postrst", 2, 8'h10, 8'h20, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int unsigned a, d, op;
      bit r;
      op = $urandom_range(0, 7);
      a  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      d  = $urandom_range(0, 255);
      r  = ($urandom_range(0, 15) == 0);
      run($sformatf("rnd%0d", i), op, a, d, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
